// File: rtl/mfcc_pkg.sv
// mfcc_pkg: types and default widths shared across the MFCC front-end blocks.
package mfcc_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int CNT_W_DEF  = 16;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    FIN    = 2'd3
  } seq_state_e;

endpackage

// File: rtl/mfcc_edge_det.sv
// mfcc_edge_det: one-bit rising/falling edge detector. The input is sampled
// once per clock; the edges compare the live input against that sample.
module mfcc_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  // Register the previous value of the input (synchronous reset).
  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/mfcc_frame_seq.sv
// mfcc_frame_seq: walks the sample buffer frame by frame and streams read
// addresses with valid/ready, frame first/last markers, a done pulse and a
// sticky zero-config error.
// Optional feature: define MFCC_SEQ_ABORT_EN so that a falling edge of
// trigger during LOAD or STREAM aborts the run back to IDLE without done.
module mfcc_frame_seq
  import mfcc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              trigger,
  input  logic [31:0]       frame_num,
  input  logic [31:0]       sample_in_frame,
  input  logic [31:0]       com_2_ovl,
  input  logic              smp_ready,
  output logic              smp_valid,
  output logic [ADDR_W-1:0] smp_addr,
  output logic              frame_first,
  output logic              frame_last,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  fn_q, fn_d;      // shadow frame count
  logic [CNT_W-1:0]  spf_q, spf_d;    // shadow samples per frame
  logic [ADDR_W-1:0] hop_q, hop_d;    // shadow base advance
  logic [ADDR_W-1:0] base_q, base_d;  // base address of current frame
  logic [CNT_W-1:0]  frm_q, frm_d;    // current frame index
  logic [CNT_W-1:0]  idx_q, idx_d;    // current sample index in frame
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              trig_rise, trig_fall;
  logic              xfer;
  logic              last_smp, last_frm;
  logic [CNT_W-1:0]  idx_inc;
  logic [ADDR_W-1:0] base_inc;
  logic [CNT_W-1:0]  cfg_fn, cfg_spf;
  logic              unused_cfg;

  mfcc_edge_det u_trig_edge (
    .clk  (hclk),
    .rst  (hreset),
    .d    (trigger),
    .rise (trig_rise),
    .fall (trig_fall)
  );

  // Only the low counter/address bits of the config words matter.
  assign cfg_fn     = frame_num[CNT_W-1:0];
  assign cfg_spf    = sample_in_frame[CNT_W-1:0];
  assign unused_cfg = ^{frame_num, sample_in_frame, com_2_ovl};

  assign xfer     = valid_q & smp_ready;
  assign last_smp = (idx_q == spf_q - CNT_ONE);
  assign last_frm = (frm_q == fn_q - CNT_ONE);
  assign idx_inc  = idx_q + CNT_ONE;
  assign base_inc = base_q + hop_q;

`ifndef MFCC_SEQ_ABORT_EN
  logic unused_trig_fall;
  assign unused_trig_fall = trig_fall;
`endif

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    fn_d    = fn_q;
    spf_d   = spf_q;
    hop_d   = hop_q;
    base_d  = base_q;
    frm_d   = frm_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    first_d = first_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (trig_rise) begin
          state_d = LOAD;
          busy_d  = 1'b1;
        end
      end

      LOAD: begin
        fn_d   = cfg_fn;
        spf_d  = cfg_spf;
        hop_d  = com_2_ovl[ADDR_W-1:0];
        base_d = '0;
        frm_d  = '0;
        idx_d  = '0;
        err_d  = 1'b0;
        if (cfg_fn == '0 || cfg_spf == '0) begin
          state_d = FIN;
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          // First address is issued straight out of LOAD.
          state_d = STREAM;
          valid_d = 1'b1;
          addr_d  = '0;
          first_d = 1'b1;
          last_d  = (cfg_spf == CNT_ONE);
          busy_d  = 1'b1;
        end
      end

      STREAM: begin
        if (xfer) begin
          if (last_smp && last_frm) begin
            state_d = FIN;
            valid_d = 1'b0;
            first_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (last_smp) begin
            // Frame boundary: next frame starts one hop further on.
            base_d  = base_inc;
            frm_d   = frm_q + CNT_ONE;
            idx_d   = '0;
            addr_d  = base_inc;
            first_d = 1'b1;
            last_d  = (spf_q == CNT_ONE);
          end else begin
            idx_d   = idx_inc;
            addr_d  = base_q + ADDR_W'(idx_inc);
            first_d = 1'b0;
            last_d  = (idx_inc == spf_q - CNT_ONE);
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

`ifdef MFCC_SEQ_ABORT_EN
    // Trigger withdrawn mid-run: drop everything, no done.
    if ((state_q == LOAD || state_q == STREAM) && trig_fall) begin
      state_d = IDLE;
      valid_d = 1'b0;
      first_d = 1'b0;
      last_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
`endif
  end

  // State, shadow registers and registered outputs.
  always_ff @(posedge hclk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (hreset) begin
      state_q <= IDLE;
      fn_q    <= '0;
      spf_q   <= '0;
      hop_q   <= '0;
      base_q  <= '0;
      frm_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fn_q    <= fn_d;
      spf_q   <= spf_d;
      hop_q   <= hop_d;
      base_q  <= base_d;
      frm_q   <= frm_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign smp_valid   = valid_q;
  assign smp_addr    = addr_q;
  assign frame_first = first_q;
  assign frame_last  = last_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = err_q;

endmodule
